// File: rtl/wb_ctrl_master.sv
// wb_ctrl_master: Wishbone classic initiator for the control register slaves.
// Runs one read, write or masked poll loop per command; one response each.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_op                00 read, 01 write, 10 poll, 11 reserved
//   cmd_adr, cmd_dat      byte address; write data or poll bit mask
//   rsp_valid/err/dat     one-cycle response strobe with error flag and data
//   wb_*                  Wishbone classic initiator signals
module wb_ctrl_master #(
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned POLL_MAX = 1024,
  parameter int unsigned POLL_GAP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_dat,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  localparam logic [15:0] TO_LAST   = 16'(TIMEOUT - 1);
  localparam logic [15:0] POLL_LAST = 16'(POLL_MAX - 1);
  // A zero gap still needs one idle cycle so cyc never spans two polls.
  localparam int unsigned GAP_N     = (POLL_GAP == 0) ? 1 : POLL_GAP;
  localparam logic [7:0]  GAP_LAST  = 8'(GAP_N - 1);

  localparam logic [1:0] OP_RD   = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_POLL = 2'b10;
  localparam logic [1:0] OP_RSV  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_GAP,
    S_RESP
  } state_t;

  state_t      r_state, w_state;
  logic [1:0]  r_op, w_op;
  logic [31:0] r_adr, w_adr;
  logic [31:0] r_dat, w_dat;
  logic [15:0] r_to_cnt, w_to_cnt;
  logic [15:0] r_poll_cnt, w_poll_cnt;
  logic [7:0]  r_gap_cnt, w_gap_cnt;
  logic        r_cmd_ready, w_cmd_ready;
  logic        r_rsp_valid, w_rsp_valid;
  logic        r_rsp_err, w_rsp_err;
  logic [31:0] r_rsp_dat, w_rsp_dat;
  logic        r_stb, w_stb;
  logic        r_we, w_we;
  logic [31:0] r_wadr, w_wadr;
  logic [31:0] r_wdat, w_wdat;
  logic [3:0]  r_sel, w_sel;

  logic        w_hit;
  logic        w_last;
  logic        w_is_poll;

  assign w_hit     = |(wb_dat_i & r_dat);
  assign w_last    = (r_poll_cnt == POLL_LAST);
  assign w_is_poll = (r_op == OP_POLL);

  always_comb begin
    w_state     = r_state;
    w_op        = r_op;
    w_adr       = r_adr;
    w_dat       = r_dat;
    w_to_cnt    = r_to_cnt;
    w_poll_cnt  = r_poll_cnt;
    w_gap_cnt   = r_gap_cnt;
    w_cmd_ready = 1'b0;
    w_rsp_valid = 1'b0;
    w_rsp_err   = 1'b0;
    w_rsp_dat   = '0;
    w_stb       = r_stb;
    w_we        = r_we;
    w_wadr      = r_wadr;
    w_wdat      = r_wdat;
    w_sel       = r_sel;

    unique case (r_state)
      S_IDLE: begin
        w_cmd_ready = 1'b1;
        if (cmd_valid && r_cmd_ready) begin
          w_cmd_ready = 1'b0;
          w_op        = cmd_op;
          w_adr       = cmd_adr;
          w_dat       = cmd_dat;
          w_poll_cnt  = '0;
          w_to_cnt    = '0;
          if (cmd_op == OP_RSV) begin
            w_state     = S_RESP;
            w_rsp_valid = 1'b1;
            w_rsp_err   = 1'b1;
          end else begin
            w_state = S_BUS;
            w_stb   = 1'b1;
            w_sel   = 4'hF;
            w_wadr  = cmd_adr;
            w_we    = (cmd_op == OP_WR);
            w_wdat  = (cmd_op == OP_WR) ? cmd_dat : '0;
          end
        end
      end

      S_BUS: begin
        // stb is high for the whole of BUS, so ack is only seen here.
        if (wb_ack_i || (r_to_cnt == TO_LAST)) begin
          w_stb  = 1'b0;
          w_we   = 1'b0;
          w_sel  = '0;
          w_wadr = '0;
          w_wdat = '0;
        end
        if (wb_ack_i) begin
          unique case (1'b1)
            !w_is_poll: begin
              w_state     = S_RESP;
              w_rsp_valid = 1'b1;
              w_rsp_dat   = (r_op == OP_RD) ? wb_dat_i : '0;
            end
            w_is_poll && w_hit: begin
              w_state     = S_RESP;
              w_rsp_valid = 1'b1;
              w_rsp_dat   = wb_dat_i;
            end
            w_is_poll && !w_hit && w_last: begin
              w_state     = S_RESP;
              w_rsp_valid = 1'b1;
              w_rsp_err   = 1'b1;
              w_rsp_dat   = wb_dat_i;
            end
            w_is_poll && !w_hit && !w_last: begin
              w_state   = S_GAP;
              w_gap_cnt = '0;
            end
          endcase
          if (w_is_poll && !w_hit && (r_poll_cnt != 16'hFFFF)) begin
            w_poll_cnt = r_poll_cnt + 16'd1;
          end
        end else if (r_to_cnt == TO_LAST) begin
          w_state     = S_RESP;
          w_rsp_valid = 1'b1;
          w_rsp_err   = 1'b1;
        end else if (r_to_cnt != 16'hFFFF) begin
          w_to_cnt = r_to_cnt + 16'd1;
        end
      end

      S_GAP: begin
        if (r_gap_cnt == GAP_LAST) begin
          w_state  = S_BUS;
          w_stb    = 1'b1;
          w_sel    = 4'hF;
          w_we     = 1'b0;
          w_wadr   = r_adr;
          w_wdat   = '0;
          w_to_cnt = '0;
        end else begin
          w_gap_cnt = r_gap_cnt + 8'd1;
        end
      end

      S_RESP: begin
        w_state     = S_IDLE;
        w_cmd_ready = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op        <= '0;
      r_adr       <= '0;
      r_dat       <= '0;
      r_to_cnt    <= '0;
      r_poll_cnt  <= '0;
      r_gap_cnt   <= '0;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_dat   <= '0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_wadr      <= '0;
      r_wdat      <= '0;
      r_sel       <= '0;
    end else begin
      r_state     <= w_state;
      r_op        <= w_op;
      r_adr       <= w_adr;
      r_dat       <= w_dat;
      r_to_cnt    <= w_to_cnt;
      r_poll_cnt  <= w_poll_cnt;
      r_gap_cnt   <= w_gap_cnt;
      r_cmd_ready <= w_cmd_ready;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_err   <= w_rsp_err;
      r_rsp_dat   <= w_rsp_dat;
      r_stb       <= w_stb;
      r_we        <= w_we;
      r_wadr      <= w_wadr;
      r_wdat      <= w_wdat;
      r_sel       <= w_sel;
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_dat   = r_rsp_dat;
  assign wb_cyc_o  = r_stb;
  assign wb_stb_o  = r_stb;
  assign wb_we_o   = r_we;
  assign wb_adr_o  = r_wadr;
  assign wb_sel_o  = r_sel;
  assign wb_dat_o  = r_wdat;

endmodule

// File: tb/tb_wb_ctrl_master.sv
// tb_wb_ctrl_master: directed bench for wb_ctrl_master.
// Two instances: u0 (POLL_GAP=4) and u1 (POLL_MAX=3, POLL_GAP=0).
module tb_wb_ctrl_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cv [2];
  logic        cr [2];
  logic [1:0]  op;
  logic [31:0] cadr;
  logic [31:0] cdat;
  logic        rv [2];
  logic        re [2];
  logic [31:0] rd [2];
  logic        cyc [2];
  logic        stb [2];
  logic        we [2];
  logic [31:0] adr [2];
  logic [3:0]  sel [2];
  logic [31:0] wdo [2];
  logic [31:0] wdi [2];
  logic        ack [2];
  logic        ack_in [2];

  logic        ack_en [2];
  logic        late_ack [2];
  int          hit_n [2];
  logic [31:0] val [2];
  int          rd_cnt [2] = '{0, 0};
  int          n_wr [2] = '{0, 0};
  logic [31:0] last_wd [2];

  int n_chk = 0;
  int n_fail = 0;

  int          g_lat, g_win, g_len, g_gmin, g_gmax, g_bad;
  logic        g_err;
  logic [31:0] g_dat;

  always #5 clk = ~clk;

  wb_ctrl_master #(.TIMEOUT(10), .POLL_MAX(1024), .POLL_GAP(4)) u0 (
    .clk(clk), .rst(rst),
    .cmd_valid(cv[0]), .cmd_ready(cr[0]),
    .cmd_op(op), .cmd_adr(cadr), .cmd_dat(cdat),
    .rsp_valid(rv[0]), .rsp_err(re[0]), .rsp_dat(rd[0]),
    .wb_cyc_o(cyc[0]), .wb_stb_o(stb[0]), .wb_we_o(we[0]),
    .wb_adr_o(adr[0]), .wb_sel_o(sel[0]), .wb_dat_o(wdo[0]),
    .wb_dat_i(wdi[0]), .wb_ack_i(ack_in[0])
  );

  wb_ctrl_master #(.TIMEOUT(10), .POLL_MAX(3), .POLL_GAP(0)) u1 (
    .clk(clk), .rst(rst),
    .cmd_valid(cv[1]), .cmd_ready(cr[1]),
    .cmd_op(op), .cmd_adr(cadr), .cmd_dat(cdat),
    .rsp_valid(rv[1]), .rsp_err(re[1]), .rsp_dat(rd[1]),
    .wb_cyc_o(cyc[1]), .wb_stb_o(stb[1]), .wb_we_o(we[1]),
    .wb_adr_o(adr[1]), .wb_sel_o(sel[1]), .wb_dat_o(wdo[1]),
    .wb_dat_i(wdi[1]), .wb_ack_i(ack_in[1])
  );

  // Registered-ack slaves: one ack per access, data valid with ack.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        ack[i] <= 1'b0;
      end else begin
        ack[i] <= cyc[i] & stb[i] & ~ack[i] & ack_en[i];
        if (ack[i] && stb[i]) begin
          if (we[i]) begin
            n_wr[i]    <= n_wr[i] + 1;
            last_wd[i] <= wdo[i];
          end else begin
            rd_cnt[i] <= rd_cnt[i] + 1;
          end
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      ack_in[i] = ack[i] | late_ack[i];
      wdi[i]    = (rd_cnt[i] >= hit_n[i]) ? val[i] : 32'h0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic issue(input int i, input logic [1:0] o,
                       input logic [31:0] a, input logic [31:0] d);
    int k;
    k = 0;
    while (!cr[i] && k < 50) begin
      tick();
      k++;
    end
    chk("issue_ready", 32'(cr[i]), 32'd1);
    op    = o;
    cadr  = a;
    cdat  = d;
    cv[i] = 1'b1;
    tick();
    cv[i] = 1'b0;
  endtask

  // Watches one instance from the cycle after the handshake until rsp_valid.
  task automatic wait_rsp(input int i, input int budget, input logic ewe,
                          input logic [31:0] eadr, input logic [31:0] ewdo);
    logic prev;
    int   cur, idle;
    g_win = 0; g_len = 0; g_gmin = 999; g_gmax = 0; g_bad = 0;
    g_lat = 0; g_err = 1'b0; g_dat = '0;
    prev = 1'b0; cur = 0; idle = 0;
    for (int k = 1; k <= budget; k++) begin
      if (stb[i]) begin
        if (!prev) begin
          g_win++;
          if (g_win > 1) begin
            if (idle < g_gmin) g_gmin = idle;
            if (idle > g_gmax) g_gmax = idle;
          end
          cur = 0;
        end
        cur++;
        if (cyc[i] !== 1'b1 || sel[i] !== 4'hF || we[i] !== ewe ||
            adr[i] !== eadr || (ewe && wdo[i] !== ewdo)) g_bad++;
      end else begin
        if (prev) begin
          g_len = cur;
          idle  = 0;
        end
        idle++;
        if (cyc[i] !== 1'b0) g_bad++;
      end
      prev = stb[i];
      if (rv[i]) begin
        g_lat = k;
        g_err = re[i];
        g_dat = rd[i];
        break;
      end
      tick();
    end
  endtask

  initial begin
    int n0, seen;
    rst = 1'b1;
    cv = '{1'b0, 1'b0};
    op = 2'b00; cadr = '0; cdat = '0;
    ack_en = '{1'b1, 1'b1};
    late_ack = '{1'b0, 1'b0};
    hit_n = '{0, 0};
    val = '{32'h0, 32'h0};
    repeat (3) tick();

    for (int i = 0; i < 2; i++) begin
      chk("rst_ctl", 32'({cr[i], rv[i], re[i], cyc[i], stb[i], we[i], sel[i]}), 32'h0);
      chk("rst_rsp_dat", rd[i], 32'h0);
      chk("rst_wb_adr", adr[i], 32'h0);
      chk("rst_wb_dat", wdo[i], 32'h0);
    end
    rst = 1'b0;
    tick();
    chk("rst_rel_ready0", 32'(cr[0]), 32'd1);
    chk("rst_rel_ready1", 32'(cr[1]), 32'd1);

    // Write 0x15 to 0x08.
    n0 = n_wr[0];
    issue(0, 2'b01, 32'h08, 32'h15);
    wait_rsp(0, 20, 1'b1, 32'h08, 32'h15);
    chk("wr_lat", g_lat, 3);
    chk("wr_win", g_win, 1);
    chk("wr_len", g_len, 2);
    chk("wr_attr", g_bad, 0);
    chk("wr_err", 32'(g_err), 0);
    chk("wr_dat", g_dat, 32'h0);
    chk("wr_slave_cnt", n_wr[0] - n0, 1);
    chk("wr_slave_dat", last_wd[0], 32'h15);
    tick();
    chk("wr_pulse", 32'(rv[0]), 0);
    chk("wr_ready_back", 32'(cr[0]), 1);

    // Read 0x04 returning 1.
    val[0] = 32'h1;
    hit_n[0] = 0;
    issue(0, 2'b00, 32'h04, 32'hDEADBEEF);
    wait_rsp(0, 20, 1'b0, 32'h04, 32'h0);
    chk("rd_lat", g_lat, 3);
    chk("rd_win", g_win, 1);
    chk("rd_len", g_len, 2);
    chk("rd_attr", g_bad, 0);
    chk("rd_err", 32'(g_err), 0);
    chk("rd_dat", g_dat, 32'h1);
    tick();
    chk("rd_pulse", 32'(rv[0]), 0);

    // Poll 0x04 mask 1: reads return 0,0,0,1 with 4 idle cycles between.
    hit_n[0] = rd_cnt[0] + 3;
    val[0] = 32'h1;
    issue(0, 2'b10, 32'h04, 32'h1);
    wait_rsp(0, 60, 1'b0, 32'h04, 32'h0);
    chk("poll_lat", g_lat, 21);
    chk("poll_win", g_win, 4);
    chk("poll_len", g_len, 2);
    chk("poll_gap_min", g_gmin, 4);
    chk("poll_gap_max", g_gmax, 4);
    chk("poll_attr", g_bad, 0);
    chk("poll_err", 32'(g_err), 0);
    chk("poll_dat", g_dat, 32'h1);
    tick();

    // Exhaustion on u1: data always 0, three reads, one idle cycle between.
    hit_n[1] = 32'h7FFFFFFF;
    val[1] = 32'h1;
    issue(1, 2'b10, 32'h04, 32'h1);
    wait_rsp(1, 60, 1'b0, 32'h04, 32'h0);
    chk("exh_lat", g_lat, 9);
    chk("exh_win", g_win, 3);
    chk("exh_gap_min", g_gmin, 1);
    chk("exh_gap_max", g_gmax, 1);
    chk("exh_attr", g_bad, 0);
    chk("exh_err", 32'(g_err), 1);
    chk("exh_dat", g_dat, 32'h0);
    tick();

    // Data with bits set outside the mask still exhausts; last data returned.
    hit_n[1] = rd_cnt[1];
    val[1] = 32'hFFFFFFFD;
    issue(1, 2'b10, 32'h0C, 32'h2);
    wait_rsp(1, 60, 1'b0, 32'h0C, 32'h0);
    chk("mask_lat", g_lat, 9);
    chk("mask_win", g_win, 3);
    chk("mask_err", 32'(g_err), 1);
    chk("mask_dat", g_dat, 32'hFFFFFFFD);
    tick();

    // Same data, mask hits on the first read.
    issue(1, 2'b10, 32'h0C, 32'h4);
    wait_rsp(1, 20, 1'b0, 32'h0C, 32'h0);
    chk("hit1_lat", g_lat, 3);
    chk("hit1_win", g_win, 1);
    chk("hit1_err", 32'(g_err), 0);
    chk("hit1_dat", g_dat, 32'hFFFFFFFD);
    tick();

    // Timeout on u0: no ack, stb high 10 cycles.
    ack_en[0] = 1'b0;
    issue(0, 2'b00, 32'h10, 32'h0);
    wait_rsp(0, 40, 1'b0, 32'h10, 32'h0);
    chk("to_lat", g_lat, 11);
    chk("to_win", g_win, 1);
    chk("to_len", g_len, 10);
    chk("to_attr", g_bad, 0);
    chk("to_err", 32'(g_err), 1);
    chk("to_dat", g_dat, 32'h0);
    late_ack[0] = 1'b1;
    seen = 0;
    repeat (3) begin
      tick();
      if (rv[0] || stb[0]) seen++;
    end
    chk("to_late_ack", seen, 0);
    late_ack[0] = 1'b0;
    ack_en[0] = 1'b1;
    tick();

    // Ack arriving in the same cycle the timeout expires: ack wins.
    ack_en[1] = 1'b0;
    issue(1, 2'b00, 32'h20, 32'h0);
    repeat (9) tick();
    chk("race_stb", 32'(stb[1]), 1);
    hit_n[1] = 0;
    val[1] = 32'h5A;
    late_ack[1] = 1'b1;
    wait_rsp(1, 10, 1'b0, 32'h20, 32'h0);
    late_ack[1] = 1'b0;
    ack_en[1] = 1'b1;
    chk("race_lat", g_lat, 2);
    chk("race_err", 32'(g_err), 0);
    chk("race_dat", g_dat, 32'h5A);
    tick();

    // Reserved op: error response, no bus activity.
    issue(0, 2'b11, 32'h04, 32'h0);
    wait_rsp(0, 10, 1'b0, 32'h04, 32'h0);
    chk("rsv_lat", g_lat, 1);
    chk("rsv_win", g_win, 0);
    chk("rsv_err", 32'(g_err), 1);
    chk("rsv_dat", g_dat, 32'h0);
    tick();
    chk("rsv_ready_back", 32'(cr[0]), 1);

    // Reset during the second stb cycle of a read.
    val[0] = 32'h7;
    hit_n[0] = 0;
    issue(0, 2'b00, 32'h04, 32'h0);
    chk("rst_mid_stb1", 32'(stb[0]), 1);
    tick();
    chk("rst_mid_stb2", 32'(stb[0]), 1);
    rst = 1'b1;
    tick();
    chk("rst_mid_bus", 32'({cyc[0], stb[0], rv[0], cr[0]}), 0);
    rst = 1'b0;
    tick();
    chk("rst_mid_ready", 32'(cr[0]), 1);
    seen = 0;
    repeat (5) begin
      if (rv[0] || rv[1]) seen++;
      tick();
    end
    chk("rst_mid_no_rsp", seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_ctrl_master.md
Name: wb_ctrl_master

Overview:
Wishbone classic single-cycle initiator that drives the memory/LED control register slaves from a simple command port. Each accepted command runs as one read, one write, or a bounded poll loop that repeats reads until a masked bit is set (for example, the done flag at 0x04). It returns one response per command, with data and an error flag. A bus timeout guards against a missing ack.

Parameters:
TIMEOUT, 255, max cycles stb held without ack before the access is abandoned (1..65535)
POLL_MAX, 1024, max reads issued by one poll command (1..65535)
POLL_GAP, 4, idle cycles (cyc/stb low) between successive poll reads (0..255)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_op  in  2  00 read, 01 write, 10 poll, 11 reserved
cmd_adr  in  32  target byte address
cmd_dat  in  32  write data (write) / bit mask (poll); ignored for read
rsp_valid  out  1  one-cycle response strobe
rsp_err  out  1  qualifies rsp_valid: timeout, poll exhaustion or reserved op
rsp_dat  out  32  read data / last polled data; 0 for write and timeout
wb_cyc_o  out  1  Wishbone cycle
wb_stb_o  out  1  Wishbone strobe
wb_we_o  out  1  write enable
wb_adr_o  out  32  address
wb_sel_o  out  4  byte selects, 4'hF during every access
wb_dat_o  out  32  write data
wb_dat_i  in  32  read data
wb_ack_i  in  1  slave acknowledge

Behaviour:
- All outputs are registered. Reset values: cmd_ready=0, rsp_valid=0, rsp_err=0, rsp_dat=0, and all wb_*_o=0. The FSM returns to IDLE and all counters clear.
- rst asserted mid-access: cyc/stb drop on that same edge, and no response is ever produced for the aborted command.
- IDLE: cmd_ready=1.
  - On handshake, latch op/adr/dat and set cmd_ready=0.
  - op 11: go to RESP with err=1, dat=0. No bus activity.
  - Otherwise go to BUS. Drive cyc=stb=1 and adr, then we=1 and wb_dat_o=dat for write; we=0 for read/poll.
  - First stb cycle is the cycle after the handshake.
- BUS: cyc/stb/we/adr/dat are held stable until ack or timeout.
  - wb_ack_i is sampled only while stb=1. cyc/stb drop on the same edge that samples ack=1, so stb is never high in the cycle after ack. This prevents the registered-ack slave from seeing a second access.
  - Read: rsp_dat=wb_dat_i, go to RESP.
  - Write: rsp_dat=0, go to RESP.
  - Poll:
    - If (wb_dat_i & mask)!=0: rsp_dat=wb_dat_i, err=0, go to RESP.
    - Else increment poll_cnt. If poll_cnt==POLL_MAX: err=1, rsp_dat=last data, go to RESP.
    - Else go to GAP.
  - Timeout counter clears on entry to BUS and increments each BUS cycle without ack. When it reaches TIMEOUT: drop cyc/stb, err=1, dat=0, go to RESP.
  - An ack and the timeout in the same cycle: ack wins.
- GAP: cyc=stb=0 for exactly POLL_GAP cycles, then re-enter BUS with the same address. POLL_GAP=0 gives one idle cycle minimum; cyc is never held continuously across polls.
- RESP: rsp_valid=1 for exactly one cycle with err/dat, then IDLE.
  - cmd_ready reasserts the cycle after rsp_valid, so the next command's first stb is at least 2 cycles after the previous response.
- Latency, read/write with a zero-wait slave that acks one cycle after stb:
  - handshake edge N; stb high cycles N+1..N+2; ack sampled at N+2.
  - rsp_valid in cycle N+3; cmd_ready back in N+4.
- wb_ack_i high while stb=0 is ignored.
- Counters saturate and do not wrap: timeout counter is 16 bits, poll_cnt is 16 bits.

Test Plan:
- Write: op=01, adr=0x08, dat=0x15 against a registered-ack slave model -> one stb window of 2 cycles, we=1, sel=F, dat=0x15. rsp_valid pulse with err=0, dat=0. The slave sees exactly one write.
- Read: op=00, adr=0x04, slave returns 0x1 -> we=0, rsp_dat=0x00000001, err=0, rsp_valid 3 cycles after the handshake.
- Poll: op=10, adr=0x04, mask=0x1, slave returns 0, 0, 0, then 1, with POLL_GAP=4 -> 4 reads, each separated by 4 idle cycles. rsp_dat=1, err=0.
- Poll exhaustion: POLL_MAX=3, data always 0 -> exactly 3 reads, then rsp_err=1, rsp_dat=0.
- Timeout: no ack, TIMEOUT=10 -> stb high for 10 cycles then dropped. rsp_err=1, rsp_dat=0. A late ack afterwards is ignored.
- Reserved op 11 -> no cyc/stb activity, rsp_err=1 one cycle after acceptance.
- Reset in the 2nd cycle of a stb window -> cyc/stb low next edge, no rsp_valid, cmd_ready=1 one cycle after rst deasserts.
